// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage and architectural register file.
//
// Selects the write-back value (ALU result or load data), commits it to the
// register file at posedge, serves two combinational read ports with a
// same-cycle bypass of the write in flight, and counts retired writes.
//
// Ports:
//   clk          system clock, all state updates on posedge
//   rst          synchronous active-high reset
//   alu_in       ALU result from MEM/WB
//   mem_in       load data, aligned with MEM/WB
//   waddr_in     destination register
//   memtoReg_in  1 selects mem_in, 0 selects alu_in
//   wen_in       write enable
//   raddr1/2     decode-stage read addresses
//   rdata1/2     combinational read data (0 while rst is high)
//   wb_data      selected write-back value (not reset)
//   wb_count     registered count of committed writes, wraps
module wb_regfile #(
    parameter int DSIZE = 16,
    parameter int ASIZE = 4,
    parameter int CSIZE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] alu_in,
    input  logic [DSIZE-1:0] mem_in,
    input  logic [ASIZE-1:0] waddr_in,
    input  logic             memtoReg_in,
    input  logic             wen_in,
    input  logic [ASIZE-1:0] raddr1,
    input  logic [ASIZE-1:0] raddr2,
    output logic [DSIZE-1:0] rdata1,
    output logic [DSIZE-1:0] rdata2,
    output logic [DSIZE-1:0] wb_data,
    output logic [CSIZE-1:0] wb_count
);

    localparam int NREG = 2 ** ASIZE;

    logic [DSIZE-1:0] regs [NREG];
    logic             commit;
    logic             byp1;
    logic             byp2;

    assign wb_data = memtoReg_in ? mem_in : alu_in;

    // Register 0 is never written, so it stays at its reset value of 0.
    assign commit = wen_in && (waddr_in != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            wb_count <= '0;
        end else if (commit) begin
            regs[waddr_in] <= wb_data;
            wb_count       <= wb_count + CSIZE'(1);
        end
    end

    // Bypass only needs wen_in and an address match; address 0 is caught
    // earlier in the priority chain.
    assign byp1 = wen_in && (waddr_in == raddr1);
    assign byp2 = wen_in && (waddr_in == raddr2);

    always_comb begin
        rdata1 = regs[raddr1];
        if (rst || raddr1 == '0) begin
            rdata1 = '0;
        end else if (byp1) begin
            rdata1 = wb_data;
        end
    end

    always_comb begin
        rdata2 = regs[raddr2];
        if (rst || raddr2 == '0) begin
            rdata2 = '0;
        end else if (byp2) begin
            rdata2 = wb_data;
        end
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage plus architectural register file for the 5-stage pipeline. It consumes the MEM/WB pipeline-register outputs, selects the write-back data (ALU result or load data), and commits it to the register file on the clock edge. It serves the two decode-stage read ports with a same-cycle write-back bypass, and keeps a retired-write counter for debug and performance checks.

## Interface

Parameters:
- DSIZE, default 16 (tracks `DSIZE in define.v), data width.
- ASIZE, default 4 (tracks `ASIZE in define.v), register address width; 2^ASIZE registers.
- CSIZE, default 16, width of the retired-write counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- alu_in  in  DSIZE  ALU result from MEM/WB.
- mem_in  in  DSIZE  load data from data memory, aligned with the MEM/WB outputs.
- waddr_in  in  ASIZE  destination register from MEM/WB.
- memtoReg_in  in  1  1 selects mem_in, 0 selects alu_in.
- wen_in  in  1  write enable from MEM/WB.
- raddr1, raddr2  in  ASIZE  decode-stage read addresses.
- rdata1, rdata2  out  DSIZE  read data, combinational.
- wb_data  out  DSIZE  selected write-back value, combinational.
- wb_count  out  CSIZE  registered count of committed writes.

## Operation

- wb_data = memtoReg_in ? mem_in : alu_in. Pure mux with no state.
- Register file: 2^ASIZE entries of DSIZE bits. Entry 0 is hardwired to 0 and never written.
- Write condition: a write is committed when wen_in=1, waddr_in!=0 and rst=0. The entry at waddr_in takes wb_data at posedge.
- Read, per port n, in priority order:
  - rst=1 → rdata_n=0.
  - raddr_n=0 → 0.
  - wen_in=1 and waddr_in==raddr_n → wb_data (bypass).
  - Otherwise → the stored entry.
- Both ports may hit the same address or the bypass simultaneously; each resolves independently.
- wb_count increments by 1 at posedge on every committed write. Writes to register 0 and cycles with wen_in=0 do not count. It wraps modulo 2^CSIZE.
- Reset: on posedge with rst=1, all entries clear to 0 and wb_count clears to 0. Any write presented in that cycle is discarded.
- memtoReg_in is don't-care when wen_in=0, since it affects only wb_data.

## Timing

- Write latency: the value is committed at the posedge ending the cycle in which it is presented. It is visible from the stored array in the next cycle.
- Read latency: 0 cycles, combinational from raddr_n, the array, and the bypass inputs.
- Write-then-read hazard: a read in the same cycle as a write to that address returns the new value via bypass. No stall is required from this block.
- Reset values:
  - All entries 0.
  - wb_count 0.
  - rdata1/rdata2 are 0 while rst=1.
  - wb_data follows its inputs and is not reset.
- Reset mid-stream: asserting rst for a single cycle clears everything at that edge. A write arriving the cycle after rst deasserts commits normally.
- Back-to-back writes to the same address: the last one wins, one per cycle. The bypass always reflects the current cycle's write.
- Counter wrap: with CSIZE=16, wb_count=16'hFFFF followed by a committed write gives 16'h0000.

## Test plan

- Reset then idle: hold rst for 2 cycles, then sweep raddr1/raddr2 over 0..15 → all reads 0 and wb_count=0.
- ALU write then read: write alu_in=16'h1234 to r5 with memtoReg=0 → rdata1 for raddr1=5 is 16'h1234 in the same cycle (bypass) and in the next cycle (stored). wb_count=1.
- Load write-back: memtoReg=1, mem_in=16'hBEEF, alu_in=16'h0001, waddr=3 → wb_data=16'hBEEF and r3=16'hBEEF. Then write r3=16'h00AA on the following cycle → raddr1=raddr2=3 both read 16'h00AA via bypass, then from the array.
- Register 0 protection: wen=1, waddr=0, alu_in=16'hFFFF → raddr=0 reads 0 in both the write cycle and the next cycle. wb_count is unchanged.
- Reset during write: load r7=16'h5555, then assert rst in the same cycle as a write r7=16'hAAAA → r7=0 and wb_count=0 after the edge. A write r7=16'h0F0F on the next cycle commits.
- Counter wrap: force 65535 committed writes, then one more → wb_count goes 16'hFFFF→16'h0000. Interleave wen=0 cycles and verify they do not count.
